// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the data-memory stage.
// Helpers operate on a 64-bit word / 8-lane mask; callers truncate to DATA_W.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      SZ_D:    return |lane;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] ext_load(input logic [63:0] word, input logic [2:0] lane,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    return uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      SZ_H:    return uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_W:    return uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/sram_1p.sv
// Single-port byte-enable RAM, no reset, registered read, write-first.
module sram_1p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged;

  // Merged word doubles as the read value so a same-address write is seen.
  always_comb begin
    merged = mem_q[addr_i];
    for (int b = 0; b < NB; b++) begin
      if (we_i && be_i[b]) merged[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= merged;
      rdata_q <= merged;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: clear sweep after reset, then sized/aligned loads and stores
// with a fixed RD_LAT response pipeline.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = DATA_W / 8,
  localparam int LB            = $clog2(NB)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 init_done,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W+LB-1:0] req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output state_e               dbg_state
);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_READY;
      end
      default: begin
        req_ready = reset;
        init_done = reset;
      end
    endcase
  end

  assign dbg_state = state_q;

  logic [2:0] lane;
  logic       req_err;
  logic       accept;

  assign lane    = 3'(req_addr[LB-1:0]);
  assign req_err = ((req_size == SZ_D) && (DATA_W == 32)) || misaligned(req_size, lane);
  assign accept  = req_valid & req_ready;

  logic              ram_en, ram_we;
  logic [NB-1:0]     ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // The clear sweep owns the single RAM port until the FSM reaches READY.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = req_addr[ADDR_W+LB-1:LB];
    ram_wdata = '0;
    if (state_q == ST_CLEAR) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_be   = '1;
      ram_addr = clr_cnt_q;
    end else begin
      ram_en    = accept & ~req_err;
      ram_we    = accept & ~req_err & req_we;
      ram_be    = NB'(lane_mask(req_size, lane));
      ram_wdata = req_wdata << {lane, 3'b000};
    end
  end

  sram_1p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  logic       s1_valid_q, s1_we_q, s1_err_q, s1_uns_q;
  logic [1:0] s1_size_q;
  logic [2:0] s1_lane_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_uns_q   <= 1'b0;
      s1_size_q  <= '0;
      s1_lane_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_we_q   <= req_we;
        s1_err_q  <= req_err;
        s1_uns_q  <= req_unsigned;
        s1_size_q <= req_size;
        s1_lane_q <= lane;
      end
    end
  end

  logic              s1_rsp_err;
  logic [DATA_W-1:0] s1_rsp_rdata;

  assign s1_rsp_err   = s1_valid_q & s1_err_q;
  assign s1_rsp_rdata = (s1_valid_q && !s1_we_q && !s1_err_q)
                      ? DATA_W'(ext_load(64'(ram_rdata), s1_lane_q, s1_size_q, s1_uns_q))
                      : '0;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rsp_valid_q, rsp_err_q;
      logic [DATA_W-1:0] rsp_rdata_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end else begin
          rsp_valid_q <= s1_valid_q;
          rsp_err_q   <= s1_rsp_err;
          rsp_rdata_q <= s1_rsp_rdata;
        end
      end
      assign rsp_valid = rsp_valid_q;
      assign rsp_err   = rsp_err_q;
      assign rsp_rdata = rsp_rdata_q;
    end else begin : g_lat1
      assign rsp_valid = s1_valid_q;
      assign rsp_err   = s1_rsp_err;
      assign rsp_rdata = s1_rsp_rdata;
    end
  endgenerate

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data-memory stage for the MIPS pipeline. It replaces the fixed 1024x32 word RAM with a configurable single-port array that adds the following:
- byte, half and word (optionally dword) loads and stores with byte-lane enables
- sign or zero extension on loads
- misalignment and illegal-size detection
- 1 or 2 cycle read latency
- a sequential post-reset clear sweep instead of a parallel array reset

Sits between the ALU/EX stage and the writeback mux.

Parameters:
DATA_W, 32, word width; legal values 32 or 64; NB = DATA_W/8 byte lanes, LB = log2(NB).
ADDR_W, 10, word-address width; depth = 2**ADDR_W words.
RD_LAT, 1, response latency in cycles; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = array contents undefined, ready right after reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
init_done  out  1  high once the clear sweep is finished.
req_valid  in  1  request present.
req_ready  out  1  request can be accepted this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64).
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_W+LB  byte address.
req_wdata  in  DATA_W  store data, right-aligned (lane 0 = least significant).
rsp_valid  out  1  one-cycle pulse, one per accepted request.
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
rsp_err  out  1  qualified by rsp_valid; misaligned or illegal size.

Behaviour:
- Reset (reset=0, async): FSM goes to CLEAR (or READY if CLEAR_ON_RESET=0). Reset values: req_ready=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Response pipeline flushed; clear counter=0.
- Asserting reset mid-sweep or with requests in flight discards them, with no response. The sweep restarts from word 0 after deassertion.
- FSM states:
  - CLEAR: writes 0 to word clr_cnt each cycle and increments clr_cnt. On clr_cnt = 2**ADDR_W-1, goes to READY. Takes exactly 2**ADDR_W cycles after reset deasserts.
  - READY: req_ready=1 and init_done=1 continuously. No stall; the consumer always accepts responses.
- Accept = req_valid & req_ready. At most one request per cycle.
- Alignment: lane = req_addr[LB-1:0]. A request is misaligned when:
  - half: lane[0] != 0
  - word: lane[1:0] != 0
  - dword: lane != 0
  Size 3 with DATA_W=32 is illegal. A misaligned or illegal request performs no array access and produces rsp_err=1 with rsp_rdata=0.
- Stores:
  - Byte enables cover lanes lane .. lane+bytes-1.
  - The lane data is req_wdata shifted left by lane*8.
  - Written at the accept edge; other bytes are untouched.
  - A load accepted in the next cycle sees the new data.
- Loads:
  - The word is read at the accept edge.
  - The selected lanes are shifted right by lane*8 and extended from 8/16/32 bits per req_size and req_unsigned; dword is passed through.
  - Byte order is little-endian.
- Latency: rsp_valid is asserted exactly RD_LAT cycles after the accept edge. Back-to-back accepts give back-to-back responses in order. size, unsigned, lane and err are pipelined alongside the read.
- Out-of-range addresses are impossible, since the width matches the depth.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D
  - function lane_mask(size, lane) returning the byte-enable vector
  - function misaligned(size, lane)
  - function ext_load(word, lane, size, unsigned)
- Sub-module sram_1p (params DATA_W, ADDR_W): single-port byte-enable array with no reset, synchronous read register, write-first on same-address read/write. The controller muxes the clear-sweep port onto it.

Test Plan:
1. Reset low for 3 cycles, then high with CLEAR_ON_RESET=1, ADDR_W=10 -> req_ready=0 for exactly 1024 cycles, then init_done=1. A load word at 0x3FC returns 0x00000000.
2. Store word 0x8899AABB at 0x010, then store byte 0x5A at 0x012 -> load word at 0x010 returns 0x885AAABB. Load byte signed at 0x013 returns 0xFFFFFF88. Load byte unsigned at 0x013 returns 0x00000088.
3. Store half 0xF00D at 0x022 -> load half signed at 0x022 returns 0xFFFFF00D. Word at 0x020 has its lower half unchanged.
4. Load half at 0x011 and load word at 0x016 -> rsp_err=1 and rdata=0 for each. A following load word at 0x010 confirms memory is unchanged.
5. RD_LAT=2: issue loads on 4 consecutive cycles -> 4 consecutive rsp_valid pulses starting 2 cycles after the first accept, in issue order.
6. Assert reset while 2 loads are in flight and halfway through the sweep -> rsp_valid stays 0. After release the sweep takes the full 1024 cycles again.
